// File: rtl/clk_measure.sv
// Measures period and high time of a slow asynchronous signal in clk_in cycles.
// Optional duty measurement is enabled by defining CLK_MEASURE_DUTY_EN.
module clk_measure #(
    parameter int CNT_W   = 28,
    parameter int TIMEOUT = 24_000_000
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             locked
);

    // state   | meaning
    // IDLE    | waiting for the first rising edge after reset/clear
    // MEASURE | counting the interval since the last rising edge
    // STALL   | no rising edge for TIMEOUT cycles; counter frozen
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALL   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             meas_valid_q, meas_valid_d;
    logic             timeout_q, timeout_d;
    logic             locked_q, locked_d;
    logic             rise;
    logic             at_limit;

    assign rise     = sync2_q & ~prev_q;
    assign at_limit = (cnt_q >= TO_LIMIT);

    always_comb begin
        sync1_d      = sig_in;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        timeout_d    = timeout_q;
        locked_d     = locked_q;
        if (clear) begin
            sync1_d   = 1'b0;
            sync2_d   = 1'b0;
            prev_d    = 1'b0;
            state_d   = IDLE;
            cnt_d     = '0;
            period_d  = '0;
            timeout_d = 1'b0;
            locked_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, MEASURE: begin
                    // an edge coinciding with the limit wins over the timeout
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEASURE;
                        if (state_q == MEASURE) begin
                            period_d     = cnt_q;
                            meas_valid_d = 1'b1;
                            locked_d     = 1'b1;
                        end
                    end else if (at_limit) begin
                        state_d   = STALL;
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                STALL: begin
                    if (rise) begin
                        cnt_d     = CNT_ONE;
                        timeout_d = 1'b0;
                        state_d   = MEASURE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
            locked_q     <= locked_d;
        end
    end

`ifdef CLK_MEASURE_DUTY_EN
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             fall;

    assign fall = ~sync2_q & prev_q;

    always_comb begin
        high_d      = high_q;
        high_time_d = high_time_q;
        if (clear) begin
            high_d      = '0;
            high_time_d = '0;
        end else if (state_q == MEASURE) begin
            if (rise) begin
                high_time_d = high_q;
            end else if (fall) begin
                high_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            high_q      <= '0;
            high_time_q <= '0;
        end else begin
            high_q      <= high_d;
            high_time_q <= high_time_d;
        end
    end

    assign high_time = high_time_q;
`else
    assign high_time = '0;
`endif

    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_clk_measure.sv
// Scoreboard bench for clk_measure with TIMEOUT=1000; expected high time
// follows whether CLK_MEASURE_DUTY_EN is defined.
module tb_clk_measure;

    localparam int CNT_W   = 28;
    localparam int TIMEOUT = 1000;
`ifdef CLK_MEASURE_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic             clk_in = 1'b0;
    logic             rst_n  = 1'b0;
    logic             sig_in = 1'b0;
    logic             clear  = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;
    logic             locked;

    typedef struct {
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] hi;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks    = 0;
    int   errors    = 0;
    int   meas_seen = 0;
    int   prev_per  = 0;
    int   prev_hi   = 0;
    bit   have_prev = 1'b0;

    clk_measure #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .clear     (clear),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .timeout   (timeout),
        .locked    (locked)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // scoreboard: every meas_valid pulse must match the oldest expectation
    always @(posedge clk_in) begin
        #1;
        if (meas_valid === 1'b1) begin
            meas_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_meas_valid: got meas_valid=1 with period=%0d, expected none at %0t", period, $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (period !== mon_e.per) begin
                    errors++;
                    $display("FAIL meas_period: got %0d, expected %0d at %0t", period, mon_e.per, $time);
                end
                checks++;
                if (high_time !== mon_e.hi) begin
                    errors++;
                    $display("FAIL meas_high_time: got %0d, expected %0d at %0t", high_time, mon_e.hi, $time);
                end
                checks++;
                if (locked !== 1'b1) begin
                    errors++;
                    $display("FAIL meas_locked: got %b, expected 1 at %0t", locked, $time);
                end
            end
        end
    end

    function automatic logic [CNT_W-1:0] exp_hi(input int hi);
        return DUTY ? CNT_W'(hi) : '0;
    endfunction

    task automatic push_prev();
        exp_t e;
        if (have_prev) begin
            e.per = CNT_W'(prev_per);
            e.hi  = exp_hi(prev_hi);
            exp_q.push_back(e);
        end
    endtask

    // one sig_in period starting with a rising edge; called at a negedge
    task automatic drive_pulse(input int per, input int hi);
        push_prev();
        sig_in = 1'b1;
        repeat (hi) @(negedge clk_in);
        sig_in = 1'b0;
        repeat (per - hi) @(negedge clk_in);
        prev_per  = per;
        prev_hi   = hi;
        have_prev = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk_in);
        checks++;
        if ({period, high_time, meas_valid, timeout, locked} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got period=%0d high=%0d mv=%b to=%b lk=%b, expected all 0",
                     period, high_time, meas_valid, timeout, locked);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk_in);
        checks++;
        if ({period, high_time, meas_valid, timeout, locked} !== '0) begin
            errors++;
            $display("FAIL after_release_outputs: got period=%0d high=%0d mv=%b to=%b lk=%b, expected all 0",
                     period, high_time, meas_valid, timeout, locked);
        end
    endtask

    task automatic test_duty();
        int start;
        start     = meas_seen;
        have_prev = 1'b0;
        drive_pulse(100, 30);
        checks++;
        if (meas_seen != start || locked !== 1'b0) begin
            errors++;
            $display("FAIL first_edge_no_result: got %0d results locked=%b, expected 0 results locked=0",
                     meas_seen - start, locked);
        end
        drive_pulse(100, 30);
        checks++;
        if (meas_seen - start != 1) begin
            errors++;
            $display("FAIL duty_result_count: got %0d, expected 1", meas_seen - start);
        end
        checks++;
        if (period !== CNT_W'(100) || high_time !== exp_hi(30) || locked !== 1'b1) begin
            errors++;
            $display("FAIL duty_hold: got period=%0d high=%0d locked=%b, expected 100/%0d/1",
                     period, high_time, locked, exp_hi(30));
        end
    endtask

    task automatic test_period_change();
        int start;
        start = meas_seen;
        drive_pulse(50, 20);
        drive_pulse(50, 20);
        checks++;
        if (meas_seen - start != 2) begin
            errors++;
            $display("FAIL change_result_count: got %0d, expected 2", meas_seen - start);
        end
        checks++;
        if (period !== CNT_W'(50) || high_time !== exp_hi(20)) begin
            errors++;
            $display("FAIL change_final: got period=%0d high=%0d, expected 50/%0d", period, high_time, exp_hi(20));
        end
    endtask

    task automatic test_timeout();
        int k;
        bit seen;
        // last rising edge was 50 cycles ago; sig_in stays low
        repeat (850) @(negedge clk_in);
        checks++;
        if (timeout !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got timeout=%b locked=%b, expected 0/1", timeout, locked);
        end
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 200) begin
            @(negedge clk_in);
            k++;
            if (timeout === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || k < 101 || k > 105) begin
            errors++;
            $display("FAIL timeout_assert: got seen=%b after %0d cycles, expected within 101..105", seen, k);
        end
        checks++;
        if (locked !== 1'b0 || period !== CNT_W'(50) || high_time !== exp_hi(20)) begin
            errors++;
            $display("FAIL timeout_hold: got locked=%b period=%0d high=%0d, expected 0/50/%0d",
                     locked, period, high_time, exp_hi(20));
        end
        have_prev = 1'b0;
        drive_pulse(100, 30);
        checks++;
        if (timeout !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recover: got timeout=%b locked=%b, expected 0/0", timeout, locked);
        end
        drive_pulse(100, 30);
        checks++;
        if (locked !== 1'b1 || period !== CNT_W'(100)) begin
            errors++;
            $display("FAIL relock: got locked=%b period=%0d, expected 1/100", locked, period);
        end
    endtask

    task automatic test_clear();
        int start;
        push_prev();
        sig_in = 1'b1;
        repeat (30) @(negedge clk_in);
        sig_in = 1'b0;
        repeat (30) @(negedge clk_in);
        clear = 1'b1;
        @(negedge clk_in);
        clear = 1'b0;
        checks++;
        if ({period, high_time, meas_valid, timeout, locked} !== '0) begin
            errors++;
            $display("FAIL clear_outputs: got period=%0d high=%0d mv=%b to=%b lk=%b, expected all 0",
                     period, high_time, meas_valid, timeout, locked);
        end
        repeat (40) @(negedge clk_in);
        have_prev = 1'b0;
        start     = meas_seen;
        drive_pulse(100, 30);
        checks++;
        if (meas_seen != start || locked !== 1'b0) begin
            errors++;
            $display("FAIL clear_one_edge: got %0d results locked=%b, expected 0/0", meas_seen - start, locked);
        end
        drive_pulse(100, 30);
        checks++;
        if (meas_seen - start != 1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL clear_two_edges: got %0d results locked=%b, expected 1/1", meas_seen - start, locked);
        end
    endtask

    task automatic test_async_reset();
        push_prev();
        sig_in = 1'b1;
        repeat (20) @(negedge clk_in);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({period, high_time, meas_valid, timeout, locked} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got period=%0d high=%0d mv=%b to=%b lk=%b, expected all 0",
                     period, high_time, meas_valid, timeout, locked);
        end
        sig_in    = 1'b0;
        have_prev = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_in);
        checks++;
        if ({period, meas_valid, timeout, locked} !== '0) begin
            errors++;
            $display("FAIL async_reset_release: got period=%0d mv=%b to=%b lk=%b, expected all 0",
                     period, meas_valid, timeout, locked);
        end
    endtask

    initial begin
        @(negedge clk_in);
        test_reset();
        test_duty();
        test_period_change();
        test_timeout();
        test_clear();
        test_async_reset();
        repeat (10) @(negedge clk_in);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_measure.md
CLK_MEASURE -- requirements
Module: clk_measure

Interface
REQ-001 Parameter CNT_W, default 28, SHALL set the width of the internal counter and of the period/high_time outputs.
REQ-002 Parameter TIMEOUT, default 24_000_000, SHALL set the number of clk_in cycles without a detected rising edge after which timeout asserts; TIMEOUT SHALL be less than 2^CNT_W.
REQ-003 clk_in  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sig_in  input  1  slow signal to measure, asynchronous to clk_in.
REQ-006 clear  input  1  synchronous clear, sampled high on a clk_in rising edge.
REQ-007 period  output  CNT_W  last measured rising-to-rising interval, in clk_in cycles.
REQ-008 high_time  output  CNT_W  last measured rising-to-falling interval, in clk_in cycles.
REQ-009 meas_valid  output  1  single-cycle pulse when period/high_time update.
REQ-010 timeout  output  1  level; no rising edge seen for TIMEOUT cycles.
REQ-011 locked  output  1  level; at least one valid measurement since the last reset, clear or timeout.

Function
REQ-012 sig_in SHALL pass through a two-flop synchronizer; a third flop SHALL hold the previous synchronized value for edge detection.
REQ-013 A rising edge SHALL be detected in the cycle where the synchronized value is 1 and the previous value is 0; a falling edge, in the cycle where it is 0 and the previous value is 1.
REQ-014 FSM states: IDLE, MEASURE, STALL; reset and clear SHALL enter IDLE.
REQ-015 IDLE: cnt SHALL increment each cycle; a rising edge SHALL set cnt to 1 and move to MEASURE without a meas_valid pulse.
REQ-016 MEASURE: cnt SHALL increment each cycle; a falling edge SHALL load the high register with the current cnt value.
REQ-017 MEASURE, rising edge: period SHALL load cnt, high_time SHALL load the high register, cnt SHALL reload to 1, and meas_valid and locked SHALL assert on the following cycle. Result: period = N for rising edges N cycles apart.
REQ-018 In IDLE or MEASURE, when cnt reaches TIMEOUT without a rising edge, the FSM SHALL move to STALL, timeout SHALL assert and locked SHALL deassert; period/high_time SHALL hold.
REQ-019 STALL: cnt SHALL hold; a rising edge SHALL clear timeout, set cnt to 1 and enter MEASURE without a meas_valid pulse.
REQ-020 A rising edge in the same cycle that cnt reaches TIMEOUT SHALL be treated as an edge (no timeout).
REQ-021 A falling edge in IDLE or STALL SHALL be ignored.
REQ-022 cnt SHALL never wrap.
REQ-023 clear SHALL take priority over every edge and timeout event in the same cycle.
REQ-024 Detection latency SHALL be 3 clk_in cycles from a sig_in transition to the edge-detect cycle, plus 1 cycle to meas_valid.

Reset
REQ-025 When rst_n is low, all outputs and cnt SHALL be 0 and the FSM SHALL be in IDLE, independent of clk_in.
REQ-026 When clear is high, the block SHALL reach the same state as reset on the next clk_in edge.
REQ-027 The first measurement after reset or clear SHALL need two rising edges.

Configuration
REQ-028 Macro CLK_MEASURE_DUTY_EN defined: the high register, falling-edge capture and the high_time output SHALL be implemented per REQ-016/017.
REQ-029 Macro CLK_MEASURE_DUTY_EN undefined: the high register and falling-edge logic SHALL be omitted, and high_time SHALL be constant 0; all other behaviour SHALL be unchanged.

Verification (bench TIMEOUT=1000)
REQ-030 sig_in period 100 cycles, high 30, macro defined -> on the second rising edge: meas_valid one cycle, period=100, high_time=30, locked=1.
REQ-031 sig_in period 100, then switched to 50 -> next two measurements are period=100 then 50, one meas_valid each.
REQ-032 sig_in held low for 1000 cycles after the last rising edge -> timeout=1, locked=0, period unchanged; next rising edge -> timeout=0 and no meas_valid.
REQ-033 clear pulsed mid-period -> next cycle all outputs 0, IDLE; the first valid result needs two further rising edges.
REQ-034 rst_n asserted asynchronously mid-MEASURE -> outputs 0 immediately, with no meas_valid on release.
REQ-035 Macro undefined, same stimulus as REQ-030 -> period=100, high_time=0.
